xadac_stage_sb: RTL and testbench



---
 rtl/xadac_stage_sb_if.sv | 50 +++++
 rtl/xadac_stage_sb.sv | 120 ++++++++++++
 tb/tb_xadac_stage_sb.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadac_stage_sb_if.sv
// rtl/xadac_stage_sb_if.sv - xadac decode and execute channel interfaces
interface xadac_dec_if #(
  parameter int NoVs = 2
);
  typedef struct packed {
    logic [31:0] instr;
  } req_t;

  typedef struct packed {
    logic          accept;
    logic [NoVs:0] vs_read;
    logic          vd_write;
  } rsp_t;

  req_t req;
  logic req_valid;
  logic req_ready;
  rsp_t rsp;
  logic rsp_valid;
  logic rsp_ready;

  modport mst (output req, req_valid, rsp_ready, input req_ready, rsp, rsp_valid);
  modport slv (input req, req_valid, rsp_ready, output req_ready, rsp, rsp_valid);
endinterface

interface xadac_exe_if #(
  parameter int NoVs  = 2,
  parameter int RegW  = 5,
  parameter int DataW = 32
);
  typedef struct packed {
    logic [31:0]              instr;
    logic [NoVs:0][RegW-1:0]  vs_data;
  } req_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic             vd_write;
  } rsp_t;

  req_t req;
  logic req_valid;
  logic req_ready;
  rsp_t rsp;
  logic rsp_valid;
  logic rsp_ready;

  modport mst (output req, req_valid, rsp_ready, input req_ready, rsp, rsp_valid);
  modport slv (input req, req_valid, rsp_ready, output req_ready, rsp, rsp_valid);
endinterface

// File: rtl/xadac_stage_sb.sv
// rtl/xadac_stage_sb.sv - vector-register scoreboard ahead of the VRF stage
module xadac_stage_sb #(
  parameter int Depth = 4,
  parameter int NoVs  = 2,
  parameter int RegW  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  xadac_dec_if.slv                     dec_slv,
  xadac_dec_if.mst                     dec_mst,
  xadac_exe_if.slv                     exe_slv,
  xadac_exe_if.mst                     exe_mst,
  output logic                         busy,
  output logic [$clog2(Depth+1)-1:0]   count
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [RegW-1:0]  ent_q [Depth];
  logic [RegW-1:0]  ent_d [Depth];
  logic [Depth-1:0] vld_q, vld_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [RegW-1:0]  vd;
  logic             hazard;
  logic             full;
  logic             block;
  logic             push;
  logic             pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign dec_mst.req       = dec_slv.req;
  assign dec_mst.req_valid = dec_slv.req_valid;
  assign dec_slv.req_ready = dec_mst.req_ready;
  assign dec_slv.rsp       = dec_mst.rsp;
  assign dec_slv.rsp_valid = dec_mst.rsp_valid;
  assign dec_mst.rsp_ready = dec_slv.rsp_ready;

  assign vd = RegW'(exe_slv.req.instr[11:7]);

  // Only registered FIFO state feeds the hazard check, so rsp never reaches req_ready.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i <= NoVs; i++) begin
      for (int j = 0; j < Depth; j++) begin
        if (vld_q[j] && (exe_slv.req.vs_data[i] == ent_q[j])) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign full  = (cnt_q == CntW'(Depth));
  assign block = hazard | full;

  assign exe_mst.req       = exe_slv.req;
  assign exe_mst.req_valid = exe_slv.req_valid & ~block;
  assign exe_slv.req_ready = exe_mst.req_ready & ~block;

  assign exe_slv.rsp       = exe_mst.rsp;
  assign exe_slv.rsp_valid = exe_mst.rsp_valid;
  assign exe_mst.rsp_ready = exe_slv.rsp_ready;

  assign push = exe_slv.req_valid & ~block & exe_mst.req_ready;
  assign pop  = exe_mst.rsp_valid & exe_slv.rsp_ready & (cnt_q != '0);

  always_comb begin
    ent_d  = ent_q;
    vld_d  = vld_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    // Pop clears first so a same-cycle push can never be undone by it.
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = ptr_inc(rptr_q);
    end
    if (push) begin
      ent_d[wptr_q] = vd;
      vld_d[wptr_q] = 1'b1;
      wptr_d        = ptr_inc(wptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < Depth; k++) begin
        ent_q[k] <= '0;
      end
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent_q  <= ent_d;
      vld_q  <= vld_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy  = (cnt_q != '0);
  assign count = cnt_q;

  // A response with nothing pending has no request to retire.
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(exe_mst.rsp_valid && exe_slv.rsp_ready && (cnt_q == '0)));

endmodule

// File: tb/tb_xadac_stage_sb.sv
// tb/tb_xadac_stage_sb.sv - randomized bench for xadac_stage_sb with a queue-based model
module tb_xadac_stage_sb;
  localparam int DEPTH = 4;
  localparam int NOVS  = 2;
  localparam int REGW  = 5;
  localparam int DATAW = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [2:0] count;

  xadac_dec_if #(.NoVs(NOVS)) dec_s ();
  xadac_dec_if #(.NoVs(NOVS)) dec_m ();
  xadac_exe_if #(.NoVs(NOVS), .RegW(REGW), .DataW(DATAW)) exe_s ();
  xadac_exe_if #(.NoVs(NOVS), .RegW(REGW), .DataW(DATAW)) exe_m ();

  xadac_stage_sb #(.Depth(DEPTH), .NoVs(NOVS), .RegW(REGW)) dut (
    .clk     (clk),
    .rst     (rst),
    .dec_slv (dec_s),
    .dec_mst (dec_m),
    .exe_slv (exe_s),
    .exe_mst (exe_m),
    .busy    (busy),
    .count   (count)
  );

  always #5 clk = ~clk;

  logic [REGW-1:0] pend_q[$];
  bit              acc_last;
  int              checks;
  int              errors;
  bit              m_haz;
  bit              m_blk;
  bit              m_push;
  bit              m_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: pending destinations as an ordered queue; checked each negedge, then advanced.
  always @(negedge clk) begin
    if (rst) begin
      pend_q.delete();
      acc_last = 1'b0;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end else begin
      m_haz = 1'b0;
      foreach (pend_q[j]) begin
        for (int i = 0; i <= NOVS; i++) begin
          if (exe_s.req.vs_data[i] == pend_q[j]) m_haz = 1'b1;
        end
      end
      m_blk = m_haz || (pend_q.size() == DEPTH);
      chk("req_valid", 64'(exe_m.req_valid), 64'(exe_s.req_valid && !m_blk));
      chk("req_ready", 64'(exe_s.req_ready), 64'(exe_m.req_ready && !m_blk));
      chk("count", 64'(count), 64'(pend_q.size()));
      chk("busy", 64'(busy), 64'(pend_q.size() != 0));
      chk("exe_req", 64'(exe_m.req), 64'(exe_s.req));
      chk("exe_rsp", 64'(exe_s.rsp), 64'(exe_m.rsp));
      chk("exe_rsp_valid", 64'(exe_s.rsp_valid), 64'(exe_m.rsp_valid));
      chk("exe_rsp_ready", 64'(exe_m.rsp_ready), 64'(exe_s.rsp_ready));
      chk("dec_req", 64'(dec_m.req), 64'(dec_s.req));
      chk("dec_req_valid", 64'(dec_m.req_valid), 64'(dec_s.req_valid));
      chk("dec_req_ready", 64'(dec_s.req_ready), 64'(dec_m.req_ready));
      chk("dec_rsp", 64'(dec_s.rsp), 64'(dec_m.rsp));
      chk("dec_rsp_valid", 64'(dec_s.rsp_valid), 64'(dec_m.rsp_valid));
      chk("dec_rsp_ready", 64'(dec_m.rsp_ready), 64'(dec_s.rsp_ready));
      m_push = exe_s.req_valid && !m_blk && exe_m.req_ready;
      m_pop  = exe_m.rsp_valid && exe_s.rsp_ready && (pend_q.size() > 0);
      if (m_pop) void'(pend_q.pop_front());
      if (m_push) pend_q.push_back(exe_s.req.instr[11:7]);
      acc_last = m_push;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [4:0] vd, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [4:0] s2);
    logic [31:0] ins;
    ins                 = $urandom();
    ins[11:7]           = vd;
    exe_s.req.instr     = ins;
    exe_s.req.vs_data[0] = s0;
    exe_s.req.vs_data[1] = s1;
    exe_s.req.vs_data[2] = s2;
    exe_s.req_valid     = 1'b1;
  endtask

  task automatic wait_acc(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!acc_last && n < 64);
    exe_s.req_valid = 1'b0;
  endtask

  task automatic pop1();
    exe_m.rsp       = {32'($urandom()), 1'($urandom())};
    exe_m.rsp_valid = 1'b1;
    exe_s.rsp_ready = 1'b1;
    cyc();
    exe_m.rsp_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    exe_s.req_valid = 1'b0;
    while (pend_q.size() > 0 && g < 50) begin
      pop1();
      g++;
    end
    #1;
    chk("drain_count", 64'(count), 64'd0);
  endtask

  task automatic rand_dec();
    dec_s.req       = $urandom();
    dec_s.req_valid = 1'($urandom());
    dec_s.rsp_ready = 1'($urandom());
    dec_m.req_ready = 1'($urandom());
    dec_m.rsp       = 5'($urandom());
    dec_m.rsp_valid = 1'($urandom());
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    exe_s.req       = '0;
    exe_s.req_valid = 1'b0;
    exe_s.rsp_ready = 1'b0;
    exe_m.req_ready = 1'b0;
    exe_m.rsp       = '0;
    exe_m.rsp_valid = 1'b0;
    rand_dec();

    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_req_valid", 64'(exe_m.req_valid), 64'd0);

    // Independent issue fills the FIFO one per cycle.
    exe_m.req_ready = 1'b1;
    exe_s.rsp_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      set_req(5'(v), 5'd10, 5'd11, 5'd12);
      wait_acc(n);
      chk("indep_latency", 64'(n), 64'd1);
    end
    chk("indep_count", 64'(count), 64'd4);

    // Full: blocked even during the pop cycle, accepted the cycle after.
    set_req(5'd5, 5'd6, 5'd7, 5'd7);
    #1 chk("full_ready", 64'(exe_s.req_ready), 64'd0);
    cyc();
    exe_m.rsp_valid = 1'b1;
    #1 chk("full_pop_cycle", 64'(exe_s.req_ready), 64'd0);
    cyc();
    exe_m.rsp_valid = 1'b0;
    #1 chk("full_after_pop", 64'(exe_s.req_ready), 64'd1);
    cyc();
    chk("full_accepted", 64'(acc_last), 64'd1);
    chk("full_count", 64'(count), 64'd4);
    drain();

    // RAW stall released one cycle after the producer's pop.
    set_req(5'd3, 5'd20, 5'd21, 5'd22);
    wait_acc(n);
    set_req(5'd9, 5'd1, 5'd3, 5'd2);
    #1 chk("raw_blocked", 64'(exe_m.req_valid), 64'd0);
    cyc();
    exe_m.rsp_valid = 1'b1;
    #1 chk("raw_pop_cycle", 64'(exe_m.req_valid), 64'd0);
    cyc();
    exe_m.rsp_valid = 1'b0;
    #1 chk("raw_release", 64'(exe_m.req_valid), 64'd1);
    cyc();
    chk("raw_accepted", 64'(acc_last), 64'd1);
    exe_s.req_valid = 1'b0;
    drain();

    // WAW: the reader waits for both writers of v5.
    set_req(5'd5, 5'd20, 5'd21, 5'd22);
    wait_acc(n);
    set_req(5'd5, 5'd23, 5'd24, 5'd25);
    wait_acc(n);
    set_req(5'd11, 5'd5, 5'd0, 5'd0);
    #1 chk("waw_blocked", 64'(exe_m.req_valid), 64'd0);
    pop1();
    #1 chk("waw_one_left", 64'(exe_m.req_valid), 64'd0);
    pop1();
    #1 chk("waw_release", 64'(exe_m.req_valid), 64'd1);
    cyc();
    chk("waw_accepted", 64'(acc_last), 64'd1);
    exe_s.req_valid = 1'b0;
    drain();

    // Simultaneous push and pop at count 1.
    set_req(5'd9, 5'd20, 5'd21, 5'd22);
    wait_acc(n);
    set_req(5'd12, 5'd20, 5'd21, 5'd22);
    exe_m.rsp_valid = 1'b1;
    cyc();
    chk("simul_push", 64'(acc_last), 64'd1);
    exe_m.rsp_valid = 1'b0;
    exe_s.req_valid = 1'b0;
    #1 chk("simul_count", 64'(count), 64'd1);
    set_req(5'd13, 5'd9, 5'd9, 5'd9);
    #1 chk("simul_old_gone", 64'(exe_m.req_valid), 64'd1);
    wait_acc(n);
    set_req(5'd14, 5'd12, 5'd12, 5'd12);
    #1 chk("simul_new_kept", 64'(exe_m.req_valid), 64'd0);
    exe_m.rsp_valid = 1'b1;
    cyc();
    exe_m.rsp_valid = 1'b0;
    wait_acc(n);
    chk("simul_reader_acc", 64'(n), 64'd1);
    drain();

    // Reset mid-flight with a blocked request held across it.
    for (int v = 1; v <= 3; v++) begin
      set_req(5'(v), 5'd20, 5'd21, 5'd22);
      wait_acc(n);
    end
    set_req(5'd15, 5'd2, 5'd2, 5'd2);
    cyc();
    rst = 1'b1;
    #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    cyc();
    rst = 1'b0;
    #1 chk("midrst_release", 64'(exe_m.req_valid), 64'd1);
    cyc();
    chk("midrst_accepted", 64'(acc_last), 64'd1);
    exe_s.req_valid = 1'b0;
    drain();

    // Randomized traffic; requests are held until accepted.
    for (int c = 0; c < 3000; c++) begin
      if (!(exe_s.req_valid && !acc_last)) begin
        if ($urandom_range(0, 1) == 1)
          set_req(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        else
          exe_s.req_valid = 1'b0;
      end
      exe_m.req_ready = ($urandom_range(0, 3) != 0);
      exe_m.rsp       = {32'($urandom()), 1'($urandom())};
      exe_m.rsp_valid = (pend_q.size() > 0) && ($urandom_range(0, 1) == 1);
      exe_s.rsp_ready = ($urandom_range(0, 3) != 0);
      rand_dec();
      cyc();
    end
    exe_m.rsp_valid = 1'b0;
    if (exe_s.req_valid && !acc_last) begin
      exe_m.req_ready = 1'b1;
      n = 0;
      while (!acc_last && n < 64) begin
        exe_m.rsp_valid = (pend_q.size() > 0);
        cyc();
        n++;
      end
      exe_m.rsp_valid = 1'b0;
      chk("final_hold_acc", 64'(acc_last), 64'd1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
